test_clk_bank: RTL and testbench
================================

# test_clk_bank

Parametrised multi-channel successor to the single-output test clock generator used by the clock-recovery benches. Each of `CHANNELS` independent lanes produces a programmable-duty square wave with a start-up phase offset and optional periodic drift injection, so benches can exercise bandpass, drift and delta-mismatch detection in `top` without hand-built stimulus. Sits in the test tree, driven by the bench cycle counter, feeding `clks_alot_p::recovery_pins_s` and similar pin bundles.

## Interface
- `CHANNELS`, 2: number of independent clock lanes (≥1).
- `RATE_WIDTH`, `clks_alot_p::RATE_COUNTER_WIDTH`: width of rate and offset fields.
- `DRIFT_WIDTH`, 8: width of drift interval field.
- `clk`  in  1  system clock.
- `async_rst_n`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  global advance qualifier; all state holds when low.
- `init_i`  in  CHANNELS  per-lane reinitialise strobe.
- `starting_polarity_i`  in  CHANNELS  level loaded on init.
- `generation_en_i`  in  CHANNELS  per-lane run enable.
- `high_rate_i`  in  CHANNELS×RATE_WIDTH  high half-period length, enabled cycles.
- `low_rate_i`  in  CHANNELS×RATE_WIDTH  low half-period length.
- `phase_offset_i`  in  CHANNELS×RATE_WIDTH  enabled cycles waited before counting starts.
- `drift_interval_i`  in  CHANNELS×DRIFT_WIDTH  half-periods between drift injections; 0 disables.
- `drift_sign_i`  in  CHANNELS  1: stretch (+1), 0: shrink (−1).
- `clk_o`  out  CHANNELS  generated clocks.
- `rise_o`, `fall_o`  out  CHANNELS each  one-cycle pulse, registered with the `clk_o` edge.
- `drift_applied_o`  out  CHANNELS  pulse on the toggle ending a drifted half-period.

## Operation
- Lane "advance" = `clk_en & generation_en_i[n]`. Without advance, lane holds everything; edge pulses deassert.
- Per-lane FSM: IDLE → OFFSET → RUN.
  - IDLE: `clk_o` holds. On advance: go OFFSET if `phase_offset_i`≠0, else RUN; counter cleared.
  - OFFSET: counts advances; after `phase_offset_i` advances, enter RUN with counter cleared. `clk_o` holds.
  - RUN: counter increments per advance; when it reaches effective length L, `clk_o` toggles, counter clears, edge pulse fires.
- L = rate for current level (high_rate if `clk_o`=1, else low_rate), sampled at half-period start. Rate 0 treated as 1.
- Drift: half-period counter increments on each toggle; when it reaches `drift_interval_i` (≠0), the next half-period uses L+1 or max(L−1,1), the counter wraps to 0, `drift_applied_o` pulses at that half-period's end toggle. Stretch saturates at all-ones.
- `init_i[n]` (qualified by `clk_en`) from any state: IDLE, `clk_o`=`starting_polarity_i`, all counters 0, no edge pulse. Init beats advance in the same cycle.
- Rate/offset changes mid half-period take effect at the next half-period start.

## Timing
- Reset: all `clk_o`, `rise_o`, `fall_o`, `drift_applied_o` = 0; all FSMs IDLE; counters 0.
- Outputs registered; toggle is visible the cycle after the L-th advance of the half-period.
- With continuous advance and no drift: period = high+low cycles, duty = high/(high+low).
- First edge after leaving IDLE: offset + L(start level) advances.
- Lanes fully independent; no cross-lane ordering.

## Structure
- Add to `clks_alot_p`: `test_clk_state_e` {IDLE, OFFSET, RUN}; reuse `RATE_COUNTER_WIDTH`.
- One sub-module `test_clk_channel` (single lane FSM, rate/drift counters), generated `CHANNELS` times; `test_clk_bank` only slices vectors.

## Test plan
- Lane0 pol 0, high=low=4, offset 0, enable after init → `clk_o` low 4, high 4, period 8; `rise_o` every 8 cycles.
- Two lanes pol 0/1, rates 4/4 → outputs exact complements; `rise_o[0]` coincides with `fall_o[1]`.
- Offset 3, rates 2/2 → first edge 5 advances after enable.
- Drift interval 3, sign 1, rates 5/5 → every 4th half-period lasts 6 cycles, `drift_applied_o` pulses on its end edge; sign 0 → 4 cycles.
- `clk_en` low 10 cycles mid half-period → output and counters frozen, resume with remaining count.
- `init_i` mid-RUN with pol 1 → next cycle `clk_o`=1, IDLE, no edge pulse; `async_rst_n` low mid-run → all outputs 0 immediately.

Source files
------------

// File: rtl/clks_alot_p.sv
// Shared types and widths for the clock-recovery test tree.
package clks_alot_p;

  localparam int unsigned RATE_COUNTER_WIDTH = 8;

  // Per-lane test clock generator phases.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFSET = 2'd1,
    RUN    = 2'd2
  } test_clk_state_e;

endpackage

// File: rtl/test_clk_channel.sv
// Single test clock lane: phase offset, programmable half-periods, drift injection.
module test_clk_channel
  import clks_alot_p::*;
#(
  parameter int unsigned RATE_WIDTH  = RATE_COUNTER_WIDTH,
  parameter int unsigned DRIFT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   async_rst_n,
  input  logic                   clk_en,
  input  logic                   init_i,
  input  logic                   starting_polarity_i,
  input  logic                   generation_en_i,
  input  logic [RATE_WIDTH-1:0]  high_rate_i,
  input  logic [RATE_WIDTH-1:0]  low_rate_i,
  input  logic [RATE_WIDTH-1:0]  phase_offset_i,
  input  logic [DRIFT_WIDTH-1:0] drift_interval_i,
  input  logic                   drift_sign_i,
  output logic                   clk_o,
  output logic                   rise_o,
  output logic                   fall_o,
  output logic                   drift_applied_o
);

  test_clk_state_e        state_q, state_d;
  logic [RATE_WIDTH-1:0]  cnt_q, cnt_d;
  logic [RATE_WIDTH-1:0]  len_q, len_d;
  logic [DRIFT_WIDTH-1:0] hp_q, hp_d;
  logic                   drifted_q, drifted_d;
  logic                   clk_q, clk_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   drift_q, drift_d;

  logic                   advance_c;
  logic [RATE_WIDTH-1:0]  cnt_inc_c;
  logic [DRIFT_WIDTH-1:0] hp_inc_c;
  logic                   drift_hit_c;
  logic [RATE_WIDTH-1:0]  start_len_c;
  logic [RATE_WIDTH-1:0]  next_len_c;

  // Effective half-period length: zero reads as one, drift adjusts by one with saturation.
  function automatic logic [RATE_WIDTH-1:0] half_len(input logic [RATE_WIDTH-1:0] rate,
                                                     input logic drift,
                                                     input logic stretch);
    logic [RATE_WIDTH-1:0] base;
    base = (rate == '0) ? RATE_WIDTH'(1) : rate;
    if (!drift)
      return base;
    if (stretch)
      return (&base) ? base : base + RATE_WIDTH'(1);
    return (base == RATE_WIDTH'(1)) ? base : base - RATE_WIDTH'(1);
  endfunction

  assign advance_c   = clk_en & generation_en_i;
  assign cnt_inc_c   = cnt_q + RATE_WIDTH'(1);
  assign hp_inc_c    = hp_q + DRIFT_WIDTH'(1);
  assign drift_hit_c = (drift_interval_i != '0) && !drifted_q && (hp_inc_c >= drift_interval_i);
  // Length of the half-period that begins on entry to RUN (level unchanged).
  assign start_len_c = half_len(clk_q ? high_rate_i : low_rate_i, 1'b0, drift_sign_i);
  // Length of the half-period that begins on a toggle (level inverts).
  assign next_len_c  = half_len(clk_q ? low_rate_i : high_rate_i, drift_hit_c, drift_sign_i);

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    hp_d      = hp_q;
    drifted_d = drifted_q;
    clk_d     = clk_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    drift_d   = 1'b0;

    if (clk_en && init_i) begin
      state_d   = IDLE;
      clk_d     = starting_polarity_i;
      cnt_d     = '0;
      len_d     = '0;
      hp_d      = '0;
      drifted_d = 1'b0;
    end else if (advance_c) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (phase_offset_i != '0) begin
            state_d = OFFSET;
          end else begin
            state_d = RUN;
            len_d   = start_len_c;
          end
        end
        OFFSET: begin
          if (cnt_inc_c >= phase_offset_i) begin
            state_d = RUN;
            cnt_d   = '0;
            len_d   = start_len_c;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        RUN: begin
          if (cnt_inc_c >= len_q) begin
            clk_d   = ~clk_q;
            cnt_d   = '0;
            rise_d  = ~clk_q;
            fall_d  = clk_q;
            drift_d = drifted_q;
            len_d   = next_len_c;
            if (drifted_q) begin
              hp_d      = '0;
              drifted_d = 1'b0;
            end else if (drift_hit_c) begin
              hp_d      = '0;
              drifted_d = 1'b1;
            end else if (drift_interval_i == '0) begin
              hp_d = '0;
            end else begin
              hp_d = hp_inc_c;
            end
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      hp_q      <= '0;
      drifted_q <= 1'b0;
      clk_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      drift_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      hp_q      <= hp_d;
      drifted_q <= drifted_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      drift_q   <= drift_d;
    end
  end

  assign clk_o           = clk_q;
  assign rise_o          = rise_q;
  assign fall_o          = fall_q;
  assign drift_applied_o = drift_q;

endmodule

// File: rtl/test_clk_bank.sv
// Bank of independent test clock lanes; slices packed per-lane fields.
module test_clk_bank
  import clks_alot_p::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned RATE_WIDTH  = RATE_COUNTER_WIDTH,
  parameter int unsigned DRIFT_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            async_rst_n,
  input  logic                            clk_en,
  input  logic [CHANNELS-1:0]             init_i,
  input  logic [CHANNELS-1:0]             starting_polarity_i,
  input  logic [CHANNELS-1:0]             generation_en_i,
  input  logic [CHANNELS*RATE_WIDTH-1:0]  high_rate_i,
  input  logic [CHANNELS*RATE_WIDTH-1:0]  low_rate_i,
  input  logic [CHANNELS*RATE_WIDTH-1:0]  phase_offset_i,
  input  logic [CHANNELS*DRIFT_WIDTH-1:0] drift_interval_i,
  input  logic [CHANNELS-1:0]             drift_sign_i,
  output logic [CHANNELS-1:0]             clk_o,
  output logic [CHANNELS-1:0]             rise_o,
  output logic [CHANNELS-1:0]             fall_o,
  output logic [CHANNELS-1:0]             drift_applied_o
);

  // One lane per channel.
  for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
    test_clk_channel #(
      .RATE_WIDTH  (RATE_WIDTH),
      .DRIFT_WIDTH (DRIFT_WIDTH)
    ) u_lane (
      .clk                 (clk),
      .async_rst_n         (async_rst_n),
      .clk_en              (clk_en),
      .init_i              (init_i[n]),
      .starting_polarity_i (starting_polarity_i[n]),
      .generation_en_i     (generation_en_i[n]),
      .high_rate_i         (high_rate_i[n*RATE_WIDTH +: RATE_WIDTH]),
      .low_rate_i          (low_rate_i[n*RATE_WIDTH +: RATE_WIDTH]),
      .phase_offset_i      (phase_offset_i[n*RATE_WIDTH +: RATE_WIDTH]),
      .drift_interval_i    (drift_interval_i[n*DRIFT_WIDTH +: DRIFT_WIDTH]),
      .drift_sign_i        (drift_sign_i[n]),
      .clk_o               (clk_o[n]),
      .rise_o              (rise_o[n]),
      .fall_o              (fall_o[n]),
      .drift_applied_o     (drift_applied_o[n])
    );
  end

endmodule

// File: tb/tb_test_clk_bank.sv
// Directed bench for test_clk_bank: duty, complement lanes, offset, drift, freeze, init, reset.
module tb_test_clk_bank;

  localparam int unsigned CH = 2;
  localparam int unsigned RW = 8;
  localparam int unsigned DW = 8;

  logic              clk = 1'b0;
  logic              async_rst_n;
  logic              clk_en;
  logic [CH-1:0]     init_i;
  logic [CH-1:0]     starting_polarity_i;
  logic [CH-1:0]     generation_en_i;
  logic [CH*RW-1:0]  high_rate_i;
  logic [CH*RW-1:0]  low_rate_i;
  logic [CH*RW-1:0]  phase_offset_i;
  logic [CH*DW-1:0]  drift_interval_i;
  logic [CH-1:0]     drift_sign_i;
  logic [CH-1:0]     clk_o;
  logic [CH-1:0]     rise_o;
  logic [CH-1:0]     fall_o;
  logic [CH-1:0]     drift_applied_o;

  int total = 0;
  int bad   = 0;

  test_clk_bank #(.CHANNELS(CH), .RATE_WIDTH(RW), .DRIFT_WIDTH(DW)) dut (
    .clk                 (clk),
    .async_rst_n         (async_rst_n),
    .clk_en              (clk_en),
    .init_i              (init_i),
    .starting_polarity_i (starting_polarity_i),
    .generation_en_i     (generation_en_i),
    .high_rate_i         (high_rate_i),
    .low_rate_i          (low_rate_i),
    .phase_offset_i      (phase_offset_i),
    .drift_interval_i    (drift_interval_i),
    .drift_sign_i        (drift_sign_i),
    .clk_o               (clk_o),
    .rise_o              (rise_o),
    .fall_o              (fall_o),
    .drift_applied_o     (drift_applied_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int idx, input int hi, input int lo, input int off,
                          input int intv, input logic sgn);
    high_rate_i[idx*RW +: RW]      = RW'(hi);
    low_rate_i[idx*RW +: RW]       = RW'(lo);
    phase_offset_i[idx*RW +: RW]   = RW'(off);
    drift_interval_i[idx*DW +: DW] = DW'(intv);
    drift_sign_i[idx]              = sgn;
  endtask

  // Init strobe for one cycle; the following edge is the leave-IDLE advance.
  task automatic do_init(input logic [CH-1:0] mask, input logic [CH-1:0] pol);
    init_i              = mask;
    starting_polarity_i = pol;
    tick(1);
    init_i              = '0;
  endtask

  initial begin
    async_rst_n         = 1'b0;
    clk_en              = 1'b0;
    init_i              = '0;
    starting_polarity_i = '0;
    generation_en_i     = '0;
    high_rate_i         = '0;
    low_rate_i          = '0;
    phase_offset_i      = '0;
    drift_interval_i    = '0;
    drift_sign_i        = '0;

    // Reset state
    #12;
    chk("rst_clk",   32'(clk_o), 32'h0);
    chk("rst_rise",  32'(rise_o), 32'h0);
    chk("rst_fall",  32'(fall_o), 32'h0);
    chk("rst_drift", 32'(drift_applied_o), 32'h0);
    @(posedge clk);
    #1 async_rst_n = 1'b1;
    tick(1);

    // Lane0: pol 0, 4/4, no offset
    set_lane(0, 4, 4, 0, 0, 1'b1);
    clk_en          = 1'b1;
    generation_en_i = 2'b01;
    do_init(2'b01, 2'b00);
    chk("t1_init_lvl", 32'(clk_o[0]), 32'h0);
    tick(4);
    chk("t1_low4_clk",  32'(clk_o[0]), 32'h0);
    chk("t1_low4_rise", 32'(rise_o[0]), 32'h0);
    tick(1);
    chk("t1_rise_clk", 32'(clk_o[0]), 32'h1);
    chk("t1_rise_p",   32'(rise_o[0]), 32'h1);
    tick(4);
    chk("t1_fall_clk", 32'(clk_o[0]), 32'h0);
    chk("t1_fall_p",   32'(fall_o[0]), 32'h1);
    tick(3);
    chk("t1_norise7", 32'(rise_o[0]), 32'h0);
    tick(1);
    chk("t1_rise8",     32'(rise_o[0]), 32'h1);
    chk("t1_rise8_clk", 32'(clk_o[0]), 32'h1);

    // Two lanes, opposite polarity: exact complements
    set_lane(1, 4, 4, 0, 0, 1'b1);
    generation_en_i = 2'b11;
    do_init(2'b11, 2'b10);
    chk("t2_init", 32'(clk_o), 32'h2);
    tick(5);
    chk("t2_clk",  32'(clk_o), 32'h1);
    chk("t2_rise", 32'(rise_o), 32'h1);
    chk("t2_fall", 32'(fall_o), 32'h2);
    for (int k = 7; k <= 18; k++) begin
      logic e;
      tick(1);
      e = (((k - 6) / 4) % 2) == 0;
      chk("t2_compl", 32'(clk_o), 32'({~e, e}));
    end

    // Offset 3, rates 2/2 on lane0 only
    generation_en_i = 2'b01;
    set_lane(0, 2, 2, 3, 0, 1'b1);
    do_init(2'b01, 2'b00);
    tick(5);
    chk("t3_pre_edge", 32'(clk_o[0]), 32'h0);
    tick(1);
    chk("t3_edge_clk",  32'(clk_o[0]), 32'h1);
    chk("t3_edge_rise", 32'(rise_o[0]), 32'h1);

    // Drift stretch: interval 3, rates 5/5
    set_lane(0, 5, 5, 0, 3, 1'b1);
    do_init(2'b01, 2'b00);
    tick(21);
    chk("t4s_hp4_mid_clk",   32'(clk_o[0]), 32'h1);
    chk("t4s_hp4_mid_drift", 32'(drift_applied_o[0]), 32'h0);
    tick(1);
    chk("t4s_hp4_end_clk",   32'(clk_o[0]), 32'h0);
    chk("t4s_hp4_end_drift", 32'(drift_applied_o[0]), 32'h1);
    chk("t4s_hp4_end_fall",  32'(fall_o[0]), 32'h1);
    tick(1);
    chk("t4s_drift_clear", 32'(drift_applied_o[0]), 32'h0);
    tick(20);
    chk("t4s_hp8_drift", 32'(drift_applied_o[0]), 32'h1);
    chk("t4s_hp8_clk",   32'(clk_o[0]), 32'h0);

    // Drift shrink: interval 3, rates 5/5
    set_lane(0, 5, 5, 0, 3, 1'b0);
    do_init(2'b01, 2'b00);
    tick(19);
    chk("t4k_pre_clk",   32'(clk_o[0]), 32'h1);
    chk("t4k_pre_drift", 32'(drift_applied_o[0]), 32'h0);
    tick(1);
    chk("t4k_end_clk",   32'(clk_o[0]), 32'h0);
    chk("t4k_end_drift", 32'(drift_applied_o[0]), 32'h1);

    // clk_en low for 10 cycles mid half-period
    set_lane(0, 4, 4, 0, 0, 1'b1);
    do_init(2'b01, 2'b00);
    tick(5);
    chk("t5_rise_clk", 32'(clk_o[0]), 32'h1);
    tick(2);
    clk_en = 1'b0;
    tick(10);
    chk("t5_frz_clk",  32'(clk_o[0]), 32'h1);
    chk("t5_frz_rise", 32'(rise_o[0]), 32'h0);
    chk("t5_frz_fall", 32'(fall_o[0]), 32'h0);
    clk_en = 1'b1;
    tick(1);
    chk("t5_resume_clk", 32'(clk_o[0]), 32'h1);
    tick(1);
    chk("t5_end_clk",  32'(clk_o[0]), 32'h0);
    chk("t5_end_fall", 32'(fall_o[0]), 32'h1);

    // Init mid-RUN with polarity 1: no edge pulse, back to IDLE
    do_init(2'b01, 2'b01);
    chk("t6_init_clk",  32'(clk_o[0]), 32'h1);
    chk("t6_init_rise", 32'(rise_o[0]), 32'h0);
    chk("t6_init_fall", 32'(fall_o[0]), 32'h0);
    tick(4);
    chk("t6_hold_clk", 32'(clk_o[0]), 32'h1);

    // Asynchronous reset mid-run clears outputs before the next edge
    async_rst_n = 1'b0;
    #1;
    chk("t6_arst_clk",   32'(clk_o), 32'h0);
    chk("t6_arst_rise",  32'(rise_o), 32'h0);
    chk("t6_arst_fall",  32'(fall_o), 32'h0);
    chk("t6_arst_drift", 32'(drift_applied_o), 32'h0);
    tick(2);
    async_rst_n = 1'b1;
    tick(2);
    chk("t6_post_clk", 32'(clk_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
